// File: rtl/ysyx_lsu_l1d.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_lsu_l1d
// Purpose  : Load/store unit with a direct-mapped, write-through,
//            no-write-allocate L1 data cache of 2**L1D_LEN one-word lines.
//            Loads that hit answer one cycle after acceptance. Misses and
//            uncacheable loads go to the read bus. Stores always go to the
//            write bus, and a store that hits also updates the cached line.
// Ports    : clk, rst            - clock, synchronous active-high reset
//            req_*               - request from EXU (valid/ready handshake)
//            flush_i             - invalidate every line (fence)
//            resp_*              - one-cycle completion pulse, data, misalign
//            lsu_ar*/lsu_r*      - read bus (address, strobe, data, valid)
//            lsu_aw*/lsu_w*      - write bus (address, data, strobe, ready)
// Revision : 1.0  initial release
// ============================================================================
module ysyx_lsu_l1d #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int L1D_LEN = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_wen,
   input  logic [3:0]        req_alu_op,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   input  logic              flush_i,
   output logic              resp_valid,
   output logic [DATA_W-1:0] resp_rdata,
   output logic              resp_misalign,
   output logic [ADDR_W-1:0] lsu_araddr_o,
   output logic              lsu_arvalid_o,
   output logic [7:0]        lsu_rstrb_o,
   input  logic [DATA_W-1:0] lsu_rdata,
   input  logic              lsu_rvalid,
   output logic [ADDR_W-1:0] lsu_awaddr_o,
   output logic              lsu_awvalid_o,
   output logic [DATA_W-1:0] lsu_wdata_o,
   output logic [7:0]        lsu_wstrb_o,
   output logic              lsu_wvalid_o,
   input  logic              lsu_wready
);

   // Operation encoding shared with the EXU
   localparam logic [3:0] OP_LB  = 4'd0;
   localparam logic [3:0] OP_LBU = 4'd1;
   localparam logic [3:0] OP_LH  = 4'd2;
   localparam logic [3:0] OP_LHU = 4'd3;
   localparam logic [3:0] OP_LW  = 4'd4;
   localparam logic [3:0] OP_SB  = 4'd5;
   localparam logic [3:0] OP_SH  = 4'd6;
   localparam logic [3:0] OP_SW  = 4'd7;

   localparam int NLINES = 2 ** L1D_LEN;
   localparam int TAG_W  = ADDR_W - L1D_LEN - 2;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LD_BUS = 2'd1,
      ST_BUS = 2'd2,
      RESP   = 2'd3
   } state_t;

   state_t state, state_nx;

   // ------------------------------------------------------------------
   // Helpers
   // ------------------------------------------------------------------
   function automatic logic is_cacheable(input logic [ADDR_W-1:0] a);
      return ((a >= ADDR_W'(32'h3000_0000)) && (a < ADDR_W'(32'h4000_0000))) ||
             ((a >= ADDR_W'(32'h8000_0000)) && (a < ADDR_W'(32'h8040_0000))) ||
             ((a >= ADDR_W'(32'ha000_0000)) && (a < ADDR_W'(32'hc000_0000)));
   endfunction

   function automatic logic [3:0] op_strb(input logic [3:0] op);
      case (op)
         OP_LB, OP_LBU, OP_SB: op_strb = 4'b0001;
         OP_LH, OP_LHU, OP_SH: op_strb = 4'b0011;
         default:              op_strb = 4'b1111;
      endcase
   endfunction

   function automatic logic is_misaligned(input logic [3:0] op, input logic [1:0] off);
      case (op)
         OP_LH, OP_LHU, OP_SH: is_misaligned = off[0];
         OP_LW, OP_SW:         is_misaligned = (off != 2'b00);
         default:              is_misaligned = 1'b0;
      endcase
   endfunction

   // Aligned word in, lane-shifted and extended result out
   function automatic logic [DATA_W-1:0] load_ext(input logic [DATA_W-1:0] word,
                                                  input logic [3:0] op,
                                                  input logic [1:0] off);
      logic [DATA_W-1:0] sh;
      sh = word >> {off, 3'b000};
      case (op)
         OP_LB:   load_ext = {{24{sh[7]}}, sh[7:0]};
         OP_LBU:  load_ext = {24'h0, sh[7:0]};
         OP_LH:   load_ext = {{16{sh[15]}}, sh[15:0]};
         OP_LHU:  load_ext = {16'h0, sh[15:0]};
         default: load_ext = sh;
      endcase
   endfunction

   // ------------------------------------------------------------------
   // Cache storage
   // ------------------------------------------------------------------
   logic [NLINES-1:0] valid;
   logic [TAG_W-1:0]  tag_mem  [NLINES];
   logic [DATA_W-1:0] data_mem [NLINES];

   // ------------------------------------------------------------------
   // Registered request
   // ------------------------------------------------------------------
   logic [ADDR_W-1:0] addr_q;
   logic [3:0]        op_q;
   logic              wen_q;
   logic [DATA_W-1:0] wdata_q;
   logic              mis_q;
   logic [DATA_W-1:0] rdata_q;

   // Lookup on the incoming request (used for the 1-cycle hit path)
   logic [L1D_LEN-1:0] req_idx;
   logic [TAG_W-1:0]   req_tag;
   logic               req_mis;
   logic               req_hit;

   assign req_idx = req_addr[L1D_LEN+1:2];
   assign req_tag = req_addr[ADDR_W-1:L1D_LEN+2];
   assign req_mis = is_misaligned(req_alu_op, req_addr[1:0]);
   assign req_hit = is_cacheable(req_addr) && valid[req_idx] &&
                    (tag_mem[req_idx] == req_tag);

   // Lookup on the registered request (fill and store-merge paths)
   logic [L1D_LEN-1:0] q_idx;
   logic [TAG_W-1:0]   q_tag;
   logic               q_cacheable;
   logic               q_hit;
   logic [7:0]         q_strb;
   logic [DATA_W-1:0]  q_wdata_sh;

   assign q_idx       = addr_q[L1D_LEN+1:2];
   assign q_tag       = addr_q[ADDR_W-1:L1D_LEN+2];
   assign q_cacheable = is_cacheable(addr_q);
   assign q_hit       = q_cacheable && valid[q_idx] && (tag_mem[q_idx] == q_tag);
   assign q_strb      = {4'b0000, op_strb(op_q)} << addr_q[1:0];
   assign q_wdata_sh  = wdata_q << {addr_q[1:0], 3'b000};

   // A reset in the same cycle abandons the access without touching the cache
   logic fill_we;
   logic merge_we;

   assign fill_we  = !rst && (state == LD_BUS) && lsu_rvalid && q_cacheable;
   assign merge_we = !rst && (state == ST_BUS) && wen_q && lsu_wready && q_hit;

   // ------------------------------------------------------------------
   // FSM
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE: begin
            if (req_valid) begin
               if (req_mis) begin
                  state_nx = RESP;
               end else if (req_wen) begin
                  state_nx = ST_BUS;
               end else if (req_hit) begin
                  state_nx = RESP;
               end else begin
                  state_nx = LD_BUS;
               end
            end
         end
         LD_BUS: if (lsu_rvalid) state_nx = RESP;
         ST_BUS: if (lsu_wready) state_nx = RESP;
         RESP:   state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // ------------------------------------------------------------------
   // Request / response registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         addr_q  <= '0;
         op_q    <= '0;
         wen_q   <= 1'b0;
         wdata_q <= '0;
         mis_q   <= 1'b0;
         rdata_q <= '0;
      end else begin
         if ((state == IDLE) && req_valid) begin
            addr_q  <= req_addr;
            op_q    <= req_alu_op;
            wen_q   <= req_wen;
            wdata_q <= req_wdata;
            mis_q   <= req_mis;
            if (req_mis || req_wen) begin
               rdata_q <= '0;
            end else if (req_hit) begin
               rdata_q <= load_ext(data_mem[req_idx], req_alu_op, req_addr[1:0]);
            end
         end
         if ((state == LD_BUS) && lsu_rvalid) begin
            rdata_q <= load_ext(lsu_rdata, op_q, addr_q[1:0]);
         end
      end
   end

   // ------------------------------------------------------------------
   // Cache valid bits: reset beats flush, flush beats a same-cycle fill
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst || flush_i) begin
         valid <= '0;
      end else if (fill_we) begin
         valid[q_idx] <= 1'b1;
      end
   end

   // Tag/data arrays carry no reset; the valid bits guard them
   always_ff @(posedge clk) begin
      if (fill_we) begin
         data_mem[q_idx] <= lsu_rdata;
         tag_mem[q_idx]  <= q_tag;
      end else if (merge_we) begin
         for (int b = 0; b < 4; b++) begin
            if (q_strb[b]) begin
               data_mem[q_idx][8*b +: 8] <= q_wdata_sh[8*b +: 8];
            end
         end
      end
   end

   // ------------------------------------------------------------------
   // Outputs (masked while reset is asserted)
   // ------------------------------------------------------------------
   assign req_ready     = rst || (state == IDLE);
   assign resp_valid    = !rst && (state == RESP);
   assign resp_misalign = !rst && (state == RESP) && mis_q;
   assign resp_rdata    = rst ? '0 : rdata_q;

   assign lsu_araddr_o  = {addr_q[ADDR_W-1:2], 2'b00};
   assign lsu_arvalid_o = !rst && (state == LD_BUS);
   assign lsu_rstrb_o   = q_cacheable ? 8'h0f : q_strb;

   assign lsu_awaddr_o  = {addr_q[ADDR_W-1:2], 2'b00};
   assign lsu_awvalid_o = !rst && (state == ST_BUS);
   assign lsu_wvalid_o  = !rst && (state == ST_BUS);
   assign lsu_wdata_o   = q_wdata_sh;
   assign lsu_wstrb_o   = q_strb;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_lsu_l1d.sv
`default_nettype none
// ============================================================================
// Module   : tb_ysyx_lsu_l1d
// Purpose  : Directed self-checking bench for ysyx_lsu_l1d. It drives the
//            request port and acts as the bus responder. It checks hits,
//            misses, uncacheable accesses, store merge and no-allocate,
//            misalignment, flush and mid-transaction reset.
// Ports    : none (top level)
// Revision : 1.0  initial release
// ============================================================================
module tb_ysyx_lsu_l1d;

   localparam logic [3:0] LB  = 4'd0;
   localparam logic [3:0] LBU = 4'd1;
   localparam logic [3:0] LH  = 4'd2;
   localparam logic [3:0] LHU = 4'd3;
   localparam logic [3:0] LW  = 4'd4;
   localparam logic [3:0] SB  = 4'd5;
   localparam logic [3:0] SH  = 4'd6;
   localparam logic [3:0] SW  = 4'd7;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_wen;
   logic [3:0]  req_alu_op;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        flush_i;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_misalign;
   logic [31:0] lsu_araddr_o;
   logic        lsu_arvalid_o;
   logic [7:0]  lsu_rstrb_o;
   logic [31:0] lsu_rdata;
   logic        lsu_rvalid;
   logic [31:0] lsu_awaddr_o;
   logic        lsu_awvalid_o;
   logic [31:0] lsu_wdata_o;
   logic [7:0]  lsu_wstrb_o;
   logic        lsu_wvalid_o;
   logic        lsu_wready;

   int passed = 0;
   int total  = 0;
   int fails  = 0;

   ysyx_lsu_l1d #(.ADDR_W(32), .DATA_W(32), .L1D_LEN(4)) dut (
      .clk           (clk),
      .rst           (rst),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_wen       (req_wen),
      .req_alu_op    (req_alu_op),
      .req_addr      (req_addr),
      .req_wdata     (req_wdata),
      .flush_i       (flush_i),
      .resp_valid    (resp_valid),
      .resp_rdata    (resp_rdata),
      .resp_misalign (resp_misalign),
      .lsu_araddr_o  (lsu_araddr_o),
      .lsu_arvalid_o (lsu_arvalid_o),
      .lsu_rstrb_o   (lsu_rstrb_o),
      .lsu_rdata     (lsu_rdata),
      .lsu_rvalid    (lsu_rvalid),
      .lsu_awaddr_o  (lsu_awaddr_o),
      .lsu_awvalid_o (lsu_awvalid_o),
      .lsu_wdata_o   (lsu_wdata_o),
      .lsu_wstrb_o   (lsu_wstrb_o),
      .lsu_wvalid_o  (lsu_wvalid_o),
      .lsu_wready    (lsu_wready)
   );

   always #5 clk = ~clk;

   // Safety net: the directed sequence is a few hundred cycles long
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish (observed timeout, required $finish)");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s: observed 0x%08h required 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic issue(input string tag, input logic wen, input logic [3:0] op,
                        input logic [31:0] addr, input logic [31:0] wd);
      chk({tag, ".req_ready"}, 32'(req_ready), 32'd1);
      req_valid  = 1'b1;
      req_wen    = wen;
      req_alu_op = op;
      req_addr   = addr;
      req_wdata  = wd;
      tick();
      req_valid  = 1'b0;
      req_wen    = 1'b0;
      req_addr   = 32'h0;
      req_wdata  = 32'h0;
   endtask

   // Load serviced by the read bus; data returned on the waits-th bus cycle
   task automatic ld_bus(input string tag, input logic [3:0] op, input logic [31:0] addr,
                         input logic [7:0] strb, input logic [31:0] bus_data,
                         input int waits, input logic [31:0] exp);
      issue(tag, 1'b0, op, addr, 32'h0);
      chk({tag, ".arvalid"}, 32'(lsu_arvalid_o), 32'd1);
      chk({tag, ".araddr"},  lsu_araddr_o, {addr[31:2], 2'b00});
      chk({tag, ".rstrb"},   32'(lsu_rstrb_o), 32'(strb));
      for (int i = 1; i < waits; i++) begin
         tick();
         chk({tag, ".wait_arvalid"}, 32'(lsu_arvalid_o), 32'd1);
         chk({tag, ".wait_resp"},    32'(resp_valid), 32'd0);
      end
      lsu_rdata  = bus_data;
      lsu_rvalid = 1'b1;
      tick();
      lsu_rvalid = 1'b0;
      lsu_rdata  = 32'h0;
      chk({tag, ".resp_valid"}, 32'(resp_valid), 32'd1);
      chk({tag, ".rdata"},      resp_rdata, exp);
      chk({tag, ".misalign"},   32'(resp_misalign), 32'd0);
      chk({tag, ".ar_drop"},    32'(lsu_arvalid_o), 32'd0);
      tick();
      chk({tag, ".resp_pulse"}, 32'(resp_valid), 32'd0);
      chk({tag, ".rdata_hold"}, resp_rdata, exp);
   endtask

   // Load expected to hit: response one cycle after accept, no bus read
   task automatic ld_hit(input string tag, input logic [3:0] op, input logic [31:0] addr,
                         input logic [31:0] exp);
      issue(tag, 1'b0, op, addr, 32'h0);
      chk({tag, ".resp_valid"}, 32'(resp_valid), 32'd1);
      chk({tag, ".arvalid"},    32'(lsu_arvalid_o), 32'd0);
      chk({tag, ".rdata"},      resp_rdata, exp);
      tick();
      chk({tag, ".resp_pulse"}, 32'(resp_valid), 32'd0);
   endtask

   task automatic st_bus(input string tag, input logic [3:0] op, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [7:0] strb,
                         input logic [31:0] exp_wdata);
      issue(tag, 1'b1, op, addr, wd);
      chk({tag, ".awvalid"}, 32'(lsu_awvalid_o), 32'd1);
      chk({tag, ".wvalid"},  32'(lsu_wvalid_o), 32'd1);
      chk({tag, ".awaddr"},  lsu_awaddr_o, {addr[31:2], 2'b00});
      chk({tag, ".wstrb"},   32'(lsu_wstrb_o), 32'(strb));
      chk({tag, ".wdata"},   lsu_wdata_o, exp_wdata);
      tick();
      chk({tag, ".aw_hold"}, 32'(lsu_awvalid_o), 32'd1);
      lsu_wready = 1'b1;
      tick();
      lsu_wready = 1'b0;
      chk({tag, ".resp_valid"}, 32'(resp_valid), 32'd1);
      chk({tag, ".misalign"},   32'(resp_misalign), 32'd0);
      chk({tag, ".aw_drop"},    32'(lsu_awvalid_o), 32'd0);
      tick();
   endtask

   task automatic misalign(input string tag, input logic wen, input logic [3:0] op,
                           input logic [31:0] addr);
      issue(tag, wen, op, addr, 32'hffff_ffff);
      chk({tag, ".resp_valid"}, 32'(resp_valid), 32'd1);
      chk({tag, ".misalign"},   32'(resp_misalign), 32'd1);
      chk({tag, ".rdata"},      resp_rdata, 32'h0);
      chk({tag, ".arvalid"},    32'(lsu_arvalid_o), 32'd0);
      chk({tag, ".awvalid"},    32'(lsu_awvalid_o), 32'd0);
      chk({tag, ".wvalid"},     32'(lsu_wvalid_o), 32'd0);
      tick();
      chk({tag, ".resp_pulse"}, 32'(resp_valid), 32'd0);
   endtask

   initial begin
      rst        = 1'b1;
      req_valid  = 1'b0;
      req_wen    = 1'b0;
      req_alu_op = LW;
      req_addr   = 32'h0;
      req_wdata  = 32'h0;
      flush_i    = 1'b0;
      lsu_rdata  = 32'h0;
      lsu_rvalid = 1'b0;
      lsu_wready = 1'b0;

      // Reset state
      tick();
      chk("rst.req_ready",  32'(req_ready), 32'd1);
      chk("rst.resp_valid", 32'(resp_valid), 32'd0);
      chk("rst.misalign",   32'(resp_misalign), 32'd0);
      chk("rst.rdata",      resp_rdata, 32'h0);
      chk("rst.arvalid",    32'(lsu_arvalid_o), 32'd0);
      chk("rst.awvalid",    32'(lsu_awvalid_o), 32'd0);
      chk("rst.wvalid",     32'(lsu_wvalid_o), 32'd0);
      tick();
      rst = 1'b0;
      tick();

      // Fill, then hits of various widths on the same line
      ld_bus("lw_miss", LW, 32'h8000_0004, 8'h0f, 32'h1234_5678, 3, 32'h1234_5678);
      ld_hit("lw_hit",  LW, 32'h8000_0004, 32'h1234_5678);
      ld_hit("lb_hit",  LB, 32'h8000_0007, 32'h0000_0012);
      ld_hit("lh_hit",  LH, 32'h8000_0006, 32'h0000_1234);

      // Store hits merge into the line
      st_bus("sb_hit",   SB, 32'h8000_0005, 32'h0000_00ab, 8'h02, 32'h0000_ab00);
      ld_hit("lw_merge", LW, 32'h8000_0004, 32'h1234_ab78);
      st_bus("sw_hit",   SW, 32'h8000_0004, 32'h8000_ff00, 8'h0f, 32'h8000_ff00);
      ld_hit("lh_sext",  LH,  32'h8000_0004, 32'hffff_ff00);
      ld_hit("lb_sext",  LB,  32'h8000_0005, 32'hffff_ffff);
      ld_hit("lbu_zext", LBU, 32'h8000_0005, 32'h0000_00ff);
      ld_hit("lhu_zext", LHU, 32'h8000_0006, 32'h0000_8000);

      // Store miss does not allocate
      st_bus("sh_miss",    SH, 32'h8000_0102, 32'h0000_5555, 8'h0c, 32'h5555_0000);
      ld_bus("lw_noalloc", LW, 32'h8000_0100, 8'h0f, 32'hcafe_babe, 1, 32'hcafe_babe);

      // Uncacheable loads always use the bus with the op strobe
      ld_bus("uc_lw1", LW,  32'h1000_0000, 8'h0f, 32'hdead_beef, 2, 32'hdead_beef);
      ld_bus("uc_lw2", LW,  32'h1000_0000, 8'h0f, 32'h0102_0304, 1, 32'h0102_0304);
      ld_bus("uc_lh",  LH,  32'h1000_0002, 8'h0c, 32'hbeef_0000, 1, 32'hffff_beef);
      ld_bus("uc_lbu", LBU, 32'h1000_0003, 8'h08, 32'h8000_0000, 1, 32'h0000_0080);

      // Misaligned accesses
      misalign("mis_lh", 1'b0, LH, 32'h8000_0001);
      misalign("mis_lw", 1'b0, LW, 32'h8000_0002);
      misalign("mis_sw", 1'b1, SW, 32'h8000_0006);
      ld_hit("after_mis", LW, 32'h8000_0004, 32'h8000_ff00);

      // Flush invalidates the filled line
      flush_i = 1'b1;
      tick();
      flush_i = 1'b0;
      ld_bus("lw_flush",  LW, 32'h8000_0004, 8'h0f, 32'h0bad_f00d, 1, 32'h0bad_f00d);
      ld_hit("hit_flush", LW, 32'h8000_0004, 32'h0bad_f00d);

      // Reset while a load waits on the bus, with data arriving in the reset cycle
      issue("rst_mid", 1'b0, LW, 32'h8000_0040, 32'h0);
      chk("rst_mid.arvalid", 32'(lsu_arvalid_o), 32'd1);
      tick();
      rst        = 1'b1;
      lsu_rvalid = 1'b1;
      lsu_rdata  = 32'h1111_1111;
      tick();
      rst        = 1'b0;
      lsu_rvalid = 1'b0;
      lsu_rdata  = 32'h0;
      chk("rst_mid.resp_valid", 32'(resp_valid), 32'd0);
      chk("rst_mid.req_ready",  32'(req_ready), 32'd1);
      chk("rst_mid.arvalid",    32'(lsu_arvalid_o), 32'd0);
      tick();
      chk("rst_mid.no_resp",    32'(resp_valid), 32'd0);
      ld_bus("post_rst_40", LW, 32'h8000_0040, 8'h0f, 32'h2222_2222, 1, 32'h2222_2222);
      ld_bus("post_rst_04", LW, 32'h8000_0004, 8'h0f, 32'h3333_3333, 1, 32'h3333_3333);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
`default_nettype wire
